// File: rtl/s4ga_cfg_streamer_if.sv
// s4ga_cfg_streamer_if: host/fabric-side bundle of the configuration streamer.
// Ports: start/stop/wr_en/wr_addr/wr_data from the host; si_out/fpga_rst to
// the fabric plus status (busy, frame_start, sweep_done, lut_n) back to the host.
interface s4ga_cfg_streamer_if #(
  parameter int N    = 73,
  parameter int K    = 5,
  parameter int SI_W = 4
);
  localparam int N_W   = $clog2(N);
  localparam int CFG_W = K * N_W + (1 << K);

  logic             start;
  logic             stop;
  logic             wr_en;
  logic [N_W-1:0]   wr_addr;
  logic [CFG_W-1:0] wr_data;
  logic [SI_W-1:0]  si_out;
  logic             fpga_rst;
  logic             busy;
  logic             frame_start;
  logic             sweep_done;
  logic [N_W-1:0]   lut_n;

  // Host / testbench side.
  modport master (
    output start, stop, wr_en, wr_addr, wr_data,
    input  si_out, fpga_rst, busy, frame_start, sweep_done, lut_n
  );

  // Streamer side.
  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data,
    output si_out, fpga_rst, busy, frame_start, sweep_done, lut_n
  );
endinterface

// File: rtl/s4ga_cfg_streamer.sv
// s4ga_cfg_streamer: holds one config word per LUT and streams them to the
// s4ga fabric as SI_W-bit segments, LUT 0..N-1 back to back, forever, after
// an RST_CYC-cycle fabric reset. Ports: clk, rst (sync, active-high), and the
// slave side of s4ga_cfg_streamer_if (host controls/writes, fabric si/rst, status).
module s4ga_cfg_streamer #(
  parameter int N       = 73,
  parameter int K       = 5,
  parameter int SI_W    = 4,
  parameter int RST_CYC = N + 1
) (
  input  logic               clk,
  input  logic               rst,
  s4ga_cfg_streamer_if.slave bus
);

  localparam int N_W       = $clog2(N);
  localparam int MASK_W    = 1 << K;
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = K * N_W + MASK_W;
  localparam int IDX_PW    = IDX_SEGS * SI_W;
  localparam int MASK_PW   = MASK_SEGS * SI_W;
  localparam int FRM_W     = LL * SI_W;
  localparam int SEG_W     = (LL > 1) ? $clog2(LL) : 1;
  localparam int RC_W      = $clog2(RST_CYC + 1);

  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(LL - 1);
  localparam logic [SEG_W-1:0] SEG_PEN  = SEG_W'(LL - 2);
  localparam logic [N_W-1:0]   LUT_LAST = N_W'(N - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_RUN
  } state_t;

  // Lays a config word out as the on-wire frame: each index zero-extended to
  // whole segments, then the mask, MSB segment first.
  function automatic logic [FRM_W-1:0] fmt_frame(input logic [CFG_W-1:0] cfg);
    logic [FRM_W-1:0] f;
    f = '0;
    for (int k = 0; k < K; k++) begin
      f[FRM_W-1-k*IDX_PW -: IDX_PW] = IDX_PW'(cfg[CFG_W-1-k*N_W -: N_W]);
    end
    f[MASK_PW-1:0] = MASK_PW'(cfg[MASK_W-1:0]);
    return f;
  endfunction

  // Config array: written by the host, read once per frame. Not reset, so a
  // restart after rst streams the previously loaded netlist.
  logic [CFG_W-1:0] cfg_mem [N];

  logic wr_ok;
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (N_W + 1)'(N));

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      cfg_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [N_W-1:0]   lut_n_q, lut_n_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [SI_W-1:0]  si_out_q, si_out_d;
  logic             fpga_rst_q, fpga_rst_d;
  logic             busy_q, busy_d;
  logic             frame_start_q, frame_start_d;
  logic             sweep_done_q, sweep_done_d;
  logic             stop_pend_q, stop_pend_d;

  logic             lut_last;
  logic [N_W-1:0]   cap_addr;
  logic [CFG_W-1:0] cap_cfg;
  logic [FRM_W-1:0] cap_frm;

  assign lut_last = (lut_n_q == LUT_LAST);

  // LUT whose frame is loaded at the next frame boundary: 0 after RST or at
  // sweep wrap, otherwise the successor of the LUT on the wire.
  assign cap_addr = (state_q == S_RUN && !lut_last) ? (lut_n_q + 1'b1) : '0;

  // Write-through: a write landing on the capture edge itself is the value
  // the frame must carry, so bypass the array read.
  assign cap_cfg = (wr_ok && (bus.wr_addr == cap_addr)) ? bus.wr_data : cfg_mem[cap_addr];
  assign cap_frm = fmt_frame(cap_cfg);

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    seg_d         = seg_q;
    lut_n_d       = lut_n_q;
    frm_d         = frm_q;
    si_out_d      = si_out_q;
    fpga_rst_d    = fpga_rst_q;
    busy_d        = busy_q;
    frame_start_d = 1'b0;
    sweep_done_d  = 1'b0;
    stop_pend_d   = stop_pend_q;

    unique case (state_q)
      S_IDLE: begin
        si_out_d    = '0;
        fpga_rst_d  = 1'b1;
        busy_d      = 1'b0;
        lut_n_d     = '0;
        seg_d       = '0;
        stop_pend_d = 1'b0;
        // start takes priority; a simultaneous stop is dropped.
        if (bus.start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end

      S_RST: begin
        stop_pend_d = stop_pend_q | bus.stop;
        if (rst_cnt_q == RC_LAST) begin
          state_d       = S_RUN;
          fpga_rst_d    = 1'b0;
          si_out_d      = cap_frm[FRM_W-1 -: SI_W];
          frm_d         = cap_frm << SI_W;
          seg_d         = '0;
          lut_n_d       = cap_addr;
          frame_start_d = 1'b1;
          sweep_done_d  = (LL == 1) && (cap_addr == LUT_LAST);
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (seg_q == SEG_LAST) begin
          if (lut_last && (stop_pend_q || bus.stop)) begin
            // Sweep complete with a stop pending: park the fabric in reset.
            state_d     = S_IDLE;
            fpga_rst_d  = 1'b1;
            busy_d      = 1'b0;
            si_out_d    = '0;
            lut_n_d     = '0;
            seg_d       = '0;
            frm_d       = '0;
            stop_pend_d = 1'b0;
          end else begin
            stop_pend_d   = stop_pend_q | bus.stop;
            si_out_d      = cap_frm[FRM_W-1 -: SI_W];
            frm_d         = cap_frm << SI_W;
            seg_d         = '0;
            lut_n_d       = cap_addr;
            frame_start_d = 1'b1;
            sweep_done_d  = (LL == 1) && (cap_addr == LUT_LAST);
          end
        end else begin
          stop_pend_d  = stop_pend_q | bus.stop;
          si_out_d     = frm_q[FRM_W-1 -: SI_W];
          frm_d        = frm_q << SI_W;
          seg_d        = seg_q + 1'b1;
          sweep_done_d = lut_last && (seg_q == SEG_PEN);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      seg_q         <= '0;
      lut_n_q       <= '0;
      frm_q         <= '0;
      si_out_q      <= '0;
      fpga_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      stop_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      seg_q         <= seg_d;
      lut_n_q       <= lut_n_d;
      frm_q         <= frm_d;
      si_out_q      <= si_out_d;
      fpga_rst_q    <= fpga_rst_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      sweep_done_q  <= sweep_done_d;
      stop_pend_q   <= stop_pend_d;
    end
  end

  assign bus.si_out      = si_out_q;
  assign bus.fpga_rst    = fpga_rst_q;
  assign bus.busy        = busy_q;
  assign bus.frame_start = frame_start_q;
  assign bus.sweep_done  = sweep_done_q;
  assign bus.lut_n       = lut_n_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// tb_s4ga_cfg_streamer: drives random config writes, start/stop and reset
// sequences into s4ga_cfg_streamer and compares every output cycle against a
// cycle-count reference model through an expected-output queue.
module tb_s4ga_cfg_streamer;
  localparam int N         = 73;
  localparam int K         = 5;
  localparam int SI_W      = 4;
  localparam int RST_CYC   = N + 1;
  localparam int N_W       = $clog2(N);
  localparam int MASK_W    = 1 << K;
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = K * N_W + MASK_W;
  localparam int SWEEP     = N * LL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s4ga_cfg_streamer_if #(.N(N), .K(K), .SI_W(SI_W)) bus ();

  s4ga_cfg_streamer #(.N(N), .K(K), .SI_W(SI_W), .RST_CYC(RST_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [SI_W-1:0] si;
    logic            frst;
    logic            busy;
    logic            fs;
    logic            sd;
    logic [N_W-1:0]  lut;
  } obs_t;

  int errors = 0;
  int checks = 0;

  // LUT 0 is loaded with this known pattern and never rewritten.
  logic [3:0] gold [LL] = '{4'h0, 4'h5, 4'h7, 4'hF, 4'h7, 4'hE, 4'h0, 4'h0, 4'h4,
                            4'h8, 4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};

  // ---------------- reference model ----------------
  logic [CFG_W-1:0] m_cfg [N];
  int               m_t = 0;
  bit               m_act = 0;
  bit               m_stop = 0;
  int               m_segs [LL];
  obs_t             exp_q [$];

  // Segment list of one frame, built from the field values with plain arithmetic.
  function automatic void load_segs(input logic [CFG_W-1:0] c);
    logic [CFG_W-1:0] sh;
    longint unsigned  v;
    int               p;
    p = 0;
    for (int k = 0; k < K; k++) begin
      sh = c >> (MASK_W + (K - 1 - k) * N_W);
      v  = longint'(sh % (1 << N_W));
      for (int j = 0; j < IDX_SEGS; j++) begin
        m_segs[p] = int'((v >> (SI_W * (IDX_SEGS - 1 - j))) % (1 << SI_W));
        p++;
      end
    end
    v = longint'(c % (64'd1 << MASK_W));
    for (int j = 0; j < MASK_SEGS; j++) begin
      m_segs[p] = int'((v >> (SI_W * (MASK_SEGS - 1 - j))) % (1 << SI_W));
      p++;
    end
  endfunction

  // m_t counts edges since the start edge; frame f is captured at edge
  // RST_CYC + f*LL and carries LUT f mod N.
  always @(posedge clk) begin
    obs_t e;
    int   f;
    int   s;
    int   lut;
    bit   end_sweep;
    if (bus.wr_en && int'(bus.wr_addr) < N) m_cfg[bus.wr_addr] = bus.wr_data;
    if (rst) begin
      m_act  = 0;
      m_stop = 0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act  = 1;
        m_t    = 0;
        m_stop = 0;
      end
    end else begin
      m_t++;
      end_sweep = (m_t > RST_CYC) && ((m_t - RST_CYC) % SWEEP == 0);
      if (end_sweep && (m_stop || bus.stop)) begin
        m_act  = 0;
        m_stop = 0;
      end else begin
        m_stop = m_stop | bus.stop;
      end
    end
    e.si   = '0;
    e.frst = 1'b1;
    e.busy = 1'b0;
    e.fs   = 1'b0;
    e.sd   = 1'b0;
    e.lut  = '0;
    if (m_act) begin
      e.busy = 1'b1;
      if (m_t >= RST_CYC) begin
        f   = (m_t - RST_CYC) / LL;
        s   = (m_t - RST_CYC) % LL;
        lut = f % N;
        if (s == 0) load_segs(m_cfg[lut]);
        e.frst = 1'b0;
        e.si   = SI_W'(m_segs[s]);
        e.fs   = (s == 0);
        e.sd   = (lut == N - 1) && (s == LL - 1);
        e.lut  = N_W'(lut);
      end
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  int rst_len = 0;
  int g_idx   = -1;

  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    a.si   = bus.si_out;
    a.frst = bus.fpga_rst;
    a.busy = bus.busy;
    a.fs   = bus.frame_start;
    a.sd   = bus.sweep_done;
    a.lut  = bus.lut_n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 40)
          $display("FAIL outputs t=%0t got si=%h fpga_rst=%b busy=%b fs=%b sd=%b lut=%0d want si=%h fpga_rst=%b busy=%b fs=%b sd=%b lut=%0d",
                   $time, a.si, a.frst, a.busy, a.fs, a.sd, a.lut, e.si, e.frst, e.busy, e.fs, e.sd, e.lut);
      end
    end
    // Length of the fabric reset pulse that precedes the first frame.
    if (a.busy && a.frst) begin
      rst_len++;
    end else begin
      if (a.busy && a.fs && rst_len > 0) begin
        checks++;
        if (rst_len != RST_CYC) begin
          errors++;
          $display("FAIL rst_pulse_len got=%0d want=%0d", rst_len, RST_CYC);
        end
      end
      rst_len = 0;
    end
    // LUT 0 frame against the hand-derived segment sequence.
    if (!a.busy) g_idx = -1;
    else if (a.fs && a.lut == '0 && !a.frst) g_idx = 0;
    if (g_idx >= 0) begin
      checks++;
      if (a.si !== gold[g_idx]) begin
        errors++;
        $display("FAIL lut0_seg%0d got=%h want=%h", g_idx, a.si, gold[g_idx]);
      end
      g_idx++;
      if (g_idx == LL) g_idx = -1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit rnd);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
    if (rnd && $urandom_range(0, 7) == 0) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = N_W'($urandom_range(1, (1 << N_W) - 1));
      bus.wr_data = CFG_W'({$urandom, $urandom, $urandom});
    end
  endtask

  task automatic wait_frame(input int lut, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (bus.frame_start && int'(bus.lut_n) == lut) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_frame lut=%0d got=timeout want=frame_start", lut);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (!bus.busy) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle got=busy want=idle");
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with no start; a stop here must be ignored.
    for (int i = 0; i < 10; i++) begin
      step(0);
      if (i == 4) bus.stop = 1'b1;
    end

    // Load the whole array.
    step(0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = {7'h05, 7'h7F, 7'h7E, 7'h00, 7'h48, 32'hDEADBEEF};
    for (int i = 1; i < N; i++) begin
      step(0);
      bus.wr_en   = 1'b1;
      bus.wr_addr = N_W'(i);
      bus.wr_data = CFG_W'({$urandom, $urandom, $urandom});
    end

    step(0);
    bus.start = 1'b1;

    // Write hazards in sweep 1: mid-frame rewrite of the LUT on the wire,
    // then a write to the next LUT on the edge that captures it.
    wait_frame(5, RST_CYC + SWEEP + 10);
    repeat (8) step(1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = N_W'(5);
    bus.wr_data = CFG_W'({$urandom, $urandom, $urandom});
    repeat (9) step(1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = N_W'(6);
    bus.wr_data = CFG_W'({$urandom, $urandom, $urandom});

    // Sweeps 2 and 3, stop requested at LUT 10 of sweep 3.
    wait_frame(0, SWEEP + 10);
    wait_frame(0, SWEEP + 10);
    wait_frame(10, SWEEP + 10);
    bus.stop = 1'b1;
    wait_idle(SWEEP + 10);
    repeat (10) step(1);

    // Reset in the middle of LUT 30's frame.
    step(0);
    bus.start = 1'b1;
    wait_frame(30, RST_CYC + SWEEP + 10);
    repeat (7) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    repeat (5) step(1);

    // start and stop together: start wins, streaming runs past sweep 1.
    step(0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    wait_frame(0, RST_CYC + 10);
    wait_frame(0, SWEEP + 10);
    bus.stop = 1'b1;
    wait_idle(SWEEP + 10);
    repeat (10) step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s4ga_cfg_streamer.md
# s4ga_cfg_streamer

Configuration transmitter for the s4ga serial-LUT fabric. It holds one configuration word per LUT in an internal config array that a host writes. It drives the fabric's SI_W-bit segment stream and its reset line, and emits every LUT frame back to back with no bubbles, in LUT order 0..N-1, repeating forever. It sits between the host/config loader and the fabric's `{si,rst}` inputs.

## Interface
Parameters:
- N, 73: LUT count; must match fabric.
- K, 5: LUT inputs.
- SI_W, 4: segment width.
- RST_CYC, N+1: fabric reset pulse length in cycles; must be > N.

Derived values:
- N_W = clog2(N).
- MASK_W = 2^K.
- IDX_SEGS = ceil(N_W/SI_W).
- MASK_SEGS = ceil(MASK_W/SI_W).
- LL = K*IDX_SEGS + MASK_SEGS.
- CFG_W = K*N_W + MASK_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin reset-then-stream sequence; sampled in IDLE only.
- stop  in  1  request halt; honoured at the next sweep end.
- wr_en  in  1  config array write strobe.
- wr_addr  in  N_W  LUT number; writes with wr_addr ≥ N are ignored.
- wr_data  in  CFG_W  {idx0, idx1, …, idx(K-1), mask}, with idx0 in the MSBs; each idx is N_W bits.
- si_out  out  SI_W  segment to the fabric `si`; registered.
- fpga_rst  out  1  fabric reset; registered.
- busy  out  1  high in RST and RUN.
- frame_start  out  1  one-cycle pulse aligned with the first segment of each frame.
- sweep_done  out  1  one-cycle pulse aligned with the last segment of LUT N-1.
- lut_n  out  N_W  LUT number of the frame currently on si_out.

## Operation
- The FSM has three states: IDLE, RST, RUN.
- IDLE:
  - si_out=0, fpga_rst=1, busy=0, lut_n=0.
  - start=1 moves to RST. stop is ignored.
- RST:
  - Lasts exactly RST_CYC cycles: fpga_rst=1, si_out=0.
  - Then moves to RUN with n=0.
  - stop during RST is latched and honoured at the end of the first sweep.
- RUN, frame layout:
  - Each frame is LL segments, MSB segment first.
  - For k=0..K-1: idx_k is zero-extended to IDX_SEGS*SI_W bits and sent as IDX_SEGS segments.
  - Then mask is zero-extended to MASK_SEGS*SI_W bits and sent as MASK_SEGS segments.
  - idx0 is therefore the first input the fabric receives, and becomes mask-address MSB.
- RUN, sequencing:
  - The LUT counter n wraps from N-1 to 0.
  - A segment counter (0..LL-1) runs continuously.
  - Frames are contiguous: segment 0 of LUT n+1 directly follows segment LL-1 of LUT n.
- Config capture:
  - Each frame's config is captured into a CFG-wide output shift register at the clock edge that ends the previous frame (or RST).
  - A write to the same address on that same edge is captured with the new data (write-through).
  - A write to the LUT currently being transmitted does not alter the frame in flight. It takes effect on that LUT's next frame.
- Stop:
  - A pending stop (latched until consumed) is acted on at the edge ending sweep_done's cycle.
  - FSM moves to IDLE; fpga_rst=1 from the next cycle.
  - start and stop asserted in the same cycle in IDLE: start wins, stop is not latched.
- Reset:
  - rst at any time (mid-frame included) forces IDLE on the next edge and clears the pending stop and all counters.
  - The config array contents are not cleared.
  - The fabric sees fpga_rst=1 from the next cycle.
- FPGA input LUTs (n < I in the fabric) are streamed like any other frame. The fabric ignores their mask.

## Timing
- Reset values: si_out=0, fpga_rst=1, busy=0, frame_start=0, sweep_done=0, lut_n=0.
- start is sampled at edge E0. fpga_rst and busy are high for cycles E0+1 .. E0+RST_CYC.
- The first RUN cycle is E0+RST_CYC+1: fpga_rst=0, frame_start=1, lut_n=0, si_out = segment 0 of LUT 0.
- Steady state: one segment per cycle.
- frame_start has period LL. sweep_done has period N*LL.
- Write latency: a write at edge W is visible to any frame captured at edge ≥ W.
- The config array supports one write port plus one read per frame. No stall exists and none is needed.

## Test plan
- Reset: assert rst 3 cycles → si_out=0, fpga_rst=1, busy=0, frame_start=0, sweep_done=0, lut_n=0. Hold IDLE for 10 cycles with no start → outputs unchanged.
- Start timing (N=73, RST_CYC=74): pulse start at E0 → fpga_rst=1 for exactly 74 cycles, then frame_start=1, lut_n=0, fpga_rst=0.
- Frame encoding (N=73, K=5, SI_W=4, LL=18): LUT 0 written with idx = 0x05, 0x7F, 0x7E, 0x00, 0x48 and mask 0xDEADBEEF → si_out sequence 0,5,7,F,7,E,0,0,4,8,D,E,A,D,B,E,E,F.
- Sweep cadence: run 3 sweeps → sweep_done every 1314 cycles, lut_n steps 0..72 then wraps to 0, no gaps. A scoreboard reconstructs all 73 configs exactly.
- Write hazards: rewrite LUT 5 mid-frame → that frame is unchanged and the next sweep carries the new value. Write LUT 6 on the edge ending LUT 5's frame → LUT 6's frame carries the new data.
- Stop/reset: stop at LUT 10 → streaming continues through LUT 72, then IDLE with fpga_rst=1. rst at segment 7 of LUT 30 → IDLE next cycle. A following start reproduces the full RST_CYC reset pulse. Loopback into s4ga with a known netlist → io_out matches the golden model.
